// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, frame constants and grant-width helper for the Ethernet TX arbiter.
package eth_pkg;
   typedef enum logic [1:0] {IDLE, XFER, IFG, DRAIN} arb_state_t;
   localparam int ETH_MAX_FRAME = 1518;
   localparam int ETH_IFG_BYTES = 12;
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin picker, first request found searching upward from ptr+1.
module eth_rr_pick import eth_pkg::*; #(
   parameter int N = 4,
   parameter int W = id_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any_req
);
   logic [W-1:0] idx;
   // Descending scan: the last hit written is the nearest one after ptr.
   always_comb begin
      grant = '0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(ptr) + k) % N);
         if (req[idx]) grant = idx;
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level round-robin arbiter feeding one byte-wide MAC TX path.
// Define ETH_ARB_MAXLEN_EN to truncate frames at MAX_FRAME bytes (tx_abort, then DRAIN).
module eth_tx_arbiter import eth_pkg::*; #(
   parameter int N_REQ      = 4,
   parameter int IFG_CYCLES = ETH_IFG_BYTES,
   parameter int MAX_FRAME  = ETH_MAX_FRAME
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [8*N_REQ-1:0]           req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             req_ready,
   input  logic                         tx_ready,
   output logic                         tx_data_valid,
   output logic [7:0]                   tx_data_out,
   output logic                         tx_last,
   output logic                         tx_abort,
   output logic [id_width(N_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic [15:0]                  frame_count
);
   localparam int GW = id_width(N_REQ);
`ifdef ETH_ARB_MAXLEN_EN
   localparam bit MAXLEN = 1'b1;
`else
   localparam bit MAXLEN = 1'b0;
`endif
   localparam logic [15:0] IFG_LOAD = 16'(IFG_CYCLES == 0 ? 0 : IFG_CYCLES - 1);
   localparam logic [15:0] CAP_AT = 16'(MAX_FRAME - 1);
   localparam arb_state_t POST = (IFG_CYCLES == 0) ? IDLE : IFG;

   arb_state_t state, state_nxt;
   logic [GW-1:0] ptr, pick;
   logic any_req, src_valid, src_last, beat, done, cap;
   logic [7:0] src_data;
   logic [15:0] byte_cnt, ifg_cnt;

   eth_rr_pick #(.N(N_REQ), .W(GW)) u_pick (
      .req(req_valid),
      .ptr(ptr),
      .grant(pick),
      .any_req(any_req)
   );

   always_comb begin
      src_data = '0;
      for (int i = 0; i < N_REQ; i++)
         if (GW'(i) == grant_id) src_data = req_data[8*i +: 8];
   end

   assign src_valid = req_valid[grant_id];
   assign src_last = req_last[grant_id];
   assign beat = (state == XFER) && src_valid && tx_ready;
   assign done = beat && src_last;
   // Length cap fires on the beat that brings the count up to MAX_FRAME.
   assign cap = MAXLEN && beat && !src_last && (byte_cnt == CAP_AT);
   assign tx_abort = cap;
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      tx_data_valid = 1'b0;
      tx_data_out = '0;
      tx_last = 1'b0;
      case (state)
         IDLE: state_nxt = any_req ? XFER : IDLE;
         XFER: begin
            req_ready[grant_id] = tx_ready;
            tx_data_valid = src_valid;
            tx_data_out = src_data;
            tx_last = src_last || cap;
            state_nxt = done ? POST : cap ? DRAIN : XFER;
         end
         IFG: state_nxt = (ifg_cnt == '0) ? IDLE : IFG;
`ifdef ETH_ARB_MAXLEN_EN
         DRAIN: begin
            req_ready[grant_id] = 1'b1;
            state_nxt = (src_valid && src_last) ? POST : DRAIN;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant_id <= '0;
         ptr <= GW'(N_REQ - 1);
         byte_cnt <= '0;
         ifg_cnt <= '0;
         frame_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            grant_id <= pick;
            ptr <= pick;
         end
         if (done || cap) byte_cnt <= '0;
         else if (beat && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
         if (done) frame_count <= frame_count + 16'd1;
         if (state_nxt == IFG && state != IFG) ifg_cnt <= IFG_LOAD;
         else if (state == IFG && ifg_cnt != '0) ifg_cnt <= ifg_cnt - 16'd1;
      end
   end
endmodule
